vmem_stream_seq: RTL and testbench

VMEM_STREAM_SEQ -- requirements
Module: vmem_stream_seq

---
 rtl/vmem_pkg.sv | 22 ++
 rtl/vmem_alu.sv | 25 ++
 rtl/vmem_stream_seq.sv | 143 ++++++++++++++
 tb/tb_vmem_stream_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared encodings and sizing constants for the vector stream sequencer
package vmem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LEN_W_DEF  = 11;
  localparam int MAX_LEN    = 1024;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/vmem_alu.sv
// rtl/vmem_alu.sv - combinational element operation (add, sub, low-word mul, pass A)
module vmem_alu
  import vmem_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  // All results wrap naturally at W bits; no carry or overflow is reported
  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/vmem_stream_seq.sv
// rtl/vmem_stream_seq.sv - streams C += op(A, B) over a vector, one element per clock
module vmem_stream_seq
  import vmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] rv_a,
  input  logic [ADDR_W-1:0] rv_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic [ADDR_W-1:0] wd,
  output logic              we,
  output logic              busy,
  output logic              done
);

  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ADDR_W-1:0]  base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d;
  logic               wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]  wd_q, wd_d, addr_c_q, addr_c_d;
  logic [ADDR_W-1:0]  offset, alu_result;
  logic [LEN_W-1:0]   len_clamped;
  logic               launch;

  assign launch      = (state_q == ST_IDLE) && start;
  assign len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign offset      = ADDR_W'(idx_q) << 2;

  vmem_alu #(.W(ADDR_W)) u_alu (
    .op     (op_q),
    .a      (rv_a),
    .b      (rv_b),
    .result (alu_result)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: empty vectors skip straight to DONE; the last issued element moves to DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (idx_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: read addresses only while issuing, zero otherwise
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    addr_a = '0;
    addr_b = '0;
    case (state_q)
      ST_RUN: begin
        busy   = 1'b1;
        addr_a = base_a_q + offset;
        addr_b = base_b_q + offset;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign we     = wr_valid_q;
  assign wd     = wd_q;
  assign addr_c = addr_c_q;

  // Datapath next values: latch the job on launch, then register one result per RUN cycle
  always_comb begin
    op_d       = op_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    base_c_d   = base_c_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wr_valid_d = 1'b0;
    wd_d       = '0;
    addr_c_d   = '0;
    if (launch) begin
      op_d     = op_e'(op);
      base_a_d = base_a & WORD_MASK;
      base_b_d = base_b & WORD_MASK;
      base_c_d = base_c & WORD_MASK;
      len_d    = len_clamped;
      idx_d    = '0;
    end
    if (state_q == ST_RUN) begin
      idx_d      = idx_q + LEN_W'(1);
      wr_valid_d = 1'b1;
      wd_d       = alu_result;
      addr_c_d   = base_c_q + offset;
    end
  end

  // Datapath registers; reset discards any write still in the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_ADD;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_c_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wr_valid_q <= 1'b0;
      wd_q       <= '0;
      addr_c_q   <= '0;
    end else begin
      op_q       <= op_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      base_c_q   <= base_c_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wr_valid_q <= wr_valid_d;
      wd_q       <= wd_d;
      addr_c_q   <= addr_c_d;
    end
  end

endmodule

// File: tb/tb_vmem_stream_seq.sv
// tb/tb_vmem_stream_seq.sv - directed self-checking bench for vmem_stream_seq
module tb_vmem_stream_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [10:0] len = '0;
  logic [31:0] base_a = '0, base_b = '0, base_c = '0;
  logic [31:0] rv_a, rv_b, addr_a, addr_b, addr_c, wd;
  logic        we, busy, done;

  logic [31:0] mem [0:1023];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rv_a = mem[addr_a[11:2]];
  assign rv_b = mem[addr_b[11:2]];

  // Accumulating vector memory: C += wd on each write cycle
  always @(posedge clk) begin
    if (we) mem[addr_c[11:2]] = mem[addr_c[11:2]] + wd;
  end

  vmem_stream_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .len(len),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .rv_a(rv_a), .rv_b(rv_b),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .wd(wd), .we(we),
    .busy(busy), .done(done)
  );

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  // Called on a falling edge; returns on the falling edge inside cycle T0+1
  task automatic launch(input logic [1:0] o, input logic [10:0] l,
                        input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
    op = o; len = l; base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_cmp++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr_a: got %h expected 0", addr_a); end
    n_cmp++; if (addr_b !== 32'h0) begin n_fail++; $display("FAIL reset_addr_b: got %h expected 0", addr_b); end
    n_cmp++; if (addr_c !== 32'h0) begin n_fail++; $display("FAIL reset_addr_c: got %h expected 0", addr_c); end
    n_cmp++; if (wd !== 32'h0) begin n_fail++; $display("FAIL reset_wd: got %h expected 0", wd); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [31:0] e_a, e_c;
    logic e_busy, e_we, e_done;
    clear_mem();
    for (int k = 0; k < 4; k++) begin mem[k] = k + 1; mem[64 + k] = 10 * (k + 1); end
    launch(2'b00, 11'd4, 32'h000, 32'h100, 32'h200);
    for (int n = 1; n <= 7; n++) begin
      e_busy = (n >= 1 && n <= 5);
      e_we   = (n >= 2 && n <= 5);
      e_done = (n == 6);
      e_a    = (n <= 4) ? 32'h100 + 4 * (n - 1) : 32'h0;
      n_cmp++; if (busy !== e_busy) begin n_fail++; $display("FAIL add_busy T0+%0d: got %b expected %b", n, busy, e_busy); end
      n_cmp++; if (we !== e_we) begin n_fail++; $display("FAIL add_we T0+%0d: got %b expected %b", n, we, e_we); end
      n_cmp++; if (done !== e_done) begin n_fail++; $display("FAIL add_done T0+%0d: got %b expected %b", n, done, e_done); end
      n_cmp++; if (addr_b !== e_a) begin n_fail++; $display("FAIL add_addr_b T0+%0d: got %h expected %h", n, addr_b, e_a); end
      if (e_we) begin
        e_c = 32'h200 + 4 * (n - 2);
        n_cmp++; if (addr_c !== e_c) begin n_fail++; $display("FAIL add_addr_c T0+%0d: got %h expected %h", n, addr_c, e_c); end
        n_cmp++; if (wd !== 32'(11 * (n - 1))) begin n_fail++; $display("FAIL add_wd T0+%0d: got %0d expected %0d", n, wd, 11 * (n - 1)); end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[128 + k] !== 32'(11 * (k + 1))) begin n_fail++; $display("FAIL add_mem C[%0d]: got %0d expected %0d", k, mem[128 + k], 11 * (k + 1)); end
    end
  endtask

  task automatic test_sub();
    logic e_busy, e_we, e_done;
    clear_mem();
    mem[0] = 7; mem[1] = 9; mem[64] = 3; mem[65] = 4; mem[128] = 5; mem[129] = 5;
    launch(2'b01, 11'd2, 32'h000, 32'h100, 32'h200);
    for (int n = 1; n <= 5; n++) begin
      e_busy = (n >= 1 && n <= 3);
      e_we   = (n >= 2 && n <= 3);
      e_done = (n == 4);
      n_cmp++; if (busy !== e_busy) begin n_fail++; $display("FAIL sub_busy T0+%0d: got %b expected %b", n, busy, e_busy); end
      n_cmp++; if (we !== e_we) begin n_fail++; $display("FAIL sub_we T0+%0d: got %b expected %b", n, we, e_we); end
      n_cmp++; if (done !== e_done) begin n_fail++; $display("FAIL sub_done T0+%0d: got %b expected %b", n, done, e_done); end
      @(negedge clk);
    end
    n_cmp++; if (mem[128] !== 32'd9) begin n_fail++; $display("FAIL sub_mem C[0]: got %0d expected 9", mem[128]); end
    n_cmp++; if (mem[129] !== 32'd10) begin n_fail++; $display("FAIL sub_mem C[1]: got %0d expected 10", mem[129]); end
  endtask

  task automatic test_mul_pass();
    logic [1:0]  t_op [3];
    logic [31:0] t_a [3], t_b [3], t_r [3];
    t_op[0] = 2'b10; t_a[0] = 32'h0001_0000; t_b[0] = 32'h0001_0000; t_r[0] = 32'h0000_0000;
    t_op[1] = 2'b10; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'h0000_0002; t_r[1] = 32'hFFFF_FFFE;
    t_op[2] = 2'b11; t_a[2] = 32'h0000_1234; t_b[2] = 32'h0000_0007; t_r[2] = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      clear_mem();
      mem[0] = t_a[i]; mem[64] = t_b[i];
      launch(t_op[i], 11'd1, 32'h000, 32'h100, 32'h200);
      n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL mul_we_early case%0d: got %b expected 0", i, we); end
      @(negedge clk);
      n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL mul_we case%0d: got %b expected 1", i, we); end
      n_cmp++; if (wd !== t_r[i]) begin n_fail++; $display("FAIL mul_wd case%0d: got %h expected %h", i, wd, t_r[i]); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_done case%0d: got %b expected 1", i, done); end
      @(negedge clk);
    end
  endtask

  task automatic test_len_zero();
    int busy_seen, we_seen;
    busy_seen = 0; we_seen = 0;
    launch(2'b00, 11'd0, 32'h000, 32'h100, 32'h200);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done T0+1: got %b expected 1", done); end
    for (int n = 1; n <= 4; n++) begin
      if (busy) busy_seen++;
      if (we) we_seen++;
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_after: got %b expected 0", done); end
    n_cmp++; if (busy_seen != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen); end
    n_cmp++; if (we_seen != 0) begin n_fail++; $display("FAIL zero_we: got %0d write cycles expected 0", we_seen); end
  endtask

  task automatic test_len_clamp();
    int we_cnt, done_at;
    we_cnt = 0; done_at = -1;
    clear_mem();
    launch(2'b11, 11'd1500, 32'h000, 32'h100, 32'h200);
    for (int n = 1; n <= 1030; n++) begin
      if (we) we_cnt++;
      if (done && done_at < 0) done_at = n;
      @(negedge clk);
    end
    n_cmp++; if (we_cnt != 1024) begin n_fail++; $display("FAIL clamp_writes: got %0d expected 1024", we_cnt); end
    n_cmp++; if (done_at != 1026) begin n_fail++; $display("FAIL clamp_done_cycle: got T0+%0d expected T0+1026", done_at); end
  endtask

  task automatic test_reset_mid();
    int done_seen, we_seen, c_bad, done_at;
    done_seen = 0; we_seen = 0; c_bad = 0; done_at = -1;
    clear_mem();
    for (int k = 0; k < 8; k++) mem[k] = k + 1;
    launch(2'b00, 11'd8, 32'h000, 32'h100, 32'h200);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL rmid_we_before: got %b expected 1", we); end
    reset = 1'b1;
    #1;
    n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_drop: got %b expected 0", we); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_cmp++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL rmid_addr_a: got %h expected 0", addr_a); end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (done) done_seen++;
      if (we) we_seen++;
      @(negedge clk);
    end
    n_cmp++; if (done_seen != 0) begin n_fail++; $display("FAIL rmid_done: got %0d pulses expected 0", done_seen); end
    n_cmp++; if (we_seen != 0) begin n_fail++; $display("FAIL rmid_late_we: got %0d writes expected 0", we_seen); end
    n_cmp++; if (mem[128] !== 32'd1) begin n_fail++; $display("FAIL rmid_C0: got %0d expected 1", mem[128]); end
    for (int k = 1; k < 8; k++) if (mem[128 + k] !== 32'd0) c_bad++;
    n_cmp++; if (c_bad != 0) begin n_fail++; $display("FAIL rmid_C1to7: got %0d modified words expected 0", c_bad); end
    launch(2'b00, 11'd2, 32'h000, 32'h100, 32'h200);
    for (int n = 1; n <= 5; n++) begin
      if (done && done_at < 0) done_at = n;
      @(negedge clk);
    end
    n_cmp++; if (done_at != 4) begin n_fail++; $display("FAIL rmid_rerun_done: got T0+%0d expected T0+4", done_at); end
    n_cmp++; if (mem[128] !== 32'd2) begin n_fail++; $display("FAIL rmid_rerun_C0: got %0d expected 2", mem[128]); end
    n_cmp++; if (mem[129] !== 32'd2) begin n_fail++; $display("FAIL rmid_rerun_C1: got %0d expected 2", mem[129]); end
  endtask

  task automatic test_restart_wrap();
    clear_mem();
    mem[192] = 100; mem[193] = 200; mem[208] = 1; mem[209] = 2; mem[224] = 999; mem[225] = 999;
    launch(2'b00, 11'd2, 32'h300, 32'h340, 32'hFFFF_FFFC);
    start = 1'b1; base_a = 32'h380; base_c = 32'h0; len = 11'd5; op = 2'b10;
    n_cmp++; if (addr_a !== 32'h300) begin n_fail++; $display("FAIL rst_addr_a0: got %h expected 300", addr_a); end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (addr_a !== 32'h304) begin n_fail++; $display("FAIL rst_addr_a1: got %h expected 304", addr_a); end
    n_cmp++; if (addr_c !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_addr_c0: got %h expected fffffffc", addr_c); end
    n_cmp++; if (wd !== 32'd101) begin n_fail++; $display("FAIL rst_wd0: got %0d expected 101", wd); end
    @(negedge clk);
    n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL rst_we1: got %b expected 1", we); end
    n_cmp++; if (addr_c !== 32'h0) begin n_fail++; $display("FAIL rst_addr_c1: got %h expected 0", addr_c); end
    n_cmp++; if (wd !== 32'd202) begin n_fail++; $display("FAIL rst_wd1: got %0d expected 202", wd); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_done: got %b expected 1", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_done_start_busy: got %b expected 0", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_done_start_busy2: got %b expected 0", busy); end
    n_cmp++; if (mem[1023] !== 32'd101) begin n_fail++; $display("FAIL rst_mem_top: got %0d expected 101", mem[1023]); end
    n_cmp++; if (mem[0] !== 32'd202) begin n_fail++; $display("FAIL rst_mem_wrap: got %0d expected 202", mem[0]); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_add();
    test_sub();
    test_mul_pass();
    test_len_zero();
    test_len_clamp();
    test_reset_mid();
    test_restart_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
